// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: pipelined MIPS decoder with RAW interlock, redirect flush and syscall drain/halt
module pipe_ctrl_unit #(
  parameter int DEPTH = 3,
  parameter int FWD = 1,
  parameter int CW = 16
) (
  input  logic          in_clk,
  input  logic          in_rst_n,
  input  logic [31:0]   in_is,
  input  logic          in_valid,
  output logic          out_ready,
  input  logic          in_redirect,
  input  logic          in_resume,
  output logic [CW-1:0] out_ex_ctrl,
  output logic          out_ex_valid,
  output logic [CW-1:0] out_mem_ctrl,
  output logic          out_mem_valid,
  output logic [CW-1:0] out_wb_ctrl,
  output logic          out_wb_valid,
  output logic [4:0]    out_wb_reg,
  output logic          out_stall,
  output logic          out_halted
);
  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;
  state_t state_q, state_d;
  logic [31:0] id_is_q, id_is_d;
  logic id_vld_q, id_vld_d;
  logic [CW-1:0] ctrl_q [1:DEPTH];
  logic [CW-1:0] ctrl_d [1:DEPTH];
  logic vld_q [1:DEPTH];
  logic vld_d [1:DEPTH];
  logic [4:0] dst_q [1:DEPTH];
  logic [4:0] dst_d [1:DEPTH];
  logic [CW-1:0] dec_ctrl;
  logic [4:0] dec_dst;
  logic use_rs, use_rt, hazard, issue, accept, any_vld;
  logic [5:0] op, fn;
  logic [4:0] rs, rt, rd;
  logic shamt_unused;
  assign op = id_is_q[31:26];
  assign rs = id_is_q[25:21];
  assign rt = id_is_q[20:16];
  assign rd = id_is_q[15:11];
  assign fn = id_is_q[5:0];
  assign shamt_unused = ^id_is_q[10:6];
  always_comb begin
    dec_ctrl = '0;
    dec_dst = '0;
    use_rs = 1'b1;
    use_rt = 1'b0;
    if (op == 6'h00) begin
      use_rt = 1'b1;
      case (fn)
        6'h20: dec_ctrl = 16'h0100;
        6'h22: dec_ctrl = 16'h0101;
        6'h24: dec_ctrl = 16'h0102;
        6'h25: dec_ctrl = 16'h0103;
        6'h2A: dec_ctrl = 16'h0104;
        6'h00: begin dec_ctrl = 16'h0105; use_rs = 1'b0; end
        6'h02: begin dec_ctrl = 16'h0106; use_rs = 1'b0; end
        6'h08: begin dec_ctrl = 16'h0400; use_rt = 1'b0; end
        6'h0C: begin dec_ctrl = 16'h4000; use_rs = 1'b0; use_rt = 1'b0; end
        default: use_rt = 1'b0;
      endcase
      dec_dst = dec_ctrl[8] ? rd : 5'd0;
    end else begin
      case (op)
        6'h08: dec_ctrl = 16'h0110;
        6'h0C: dec_ctrl = 16'h0112;
        6'h0D: dec_ctrl = 16'h0113;
        6'h0A: dec_ctrl = 16'h0114;
        6'h23: dec_ctrl = 16'h0130;
        6'h2B: begin dec_ctrl = 16'h0050; use_rt = 1'b1; end
        6'h29: begin dec_ctrl = 16'h00D0; use_rt = 1'b1; end
        6'h04: begin dec_ctrl = 16'h0801; use_rt = 1'b1; end
        6'h05: begin dec_ctrl = 16'h1001; use_rt = 1'b1; end
        6'h02: begin dec_ctrl = 16'h0200; use_rs = 1'b0; end
        6'h03: begin dec_ctrl = 16'h2300; use_rs = 1'b0; end
        6'h10: if (rs == 5'h10 && fn == 6'h18) begin dec_ctrl = 16'h8000; use_rs = 1'b0; end
        default: ;
      endcase
      dec_dst = op == 6'h03 ? 5'd31 : (dec_ctrl[8] ? rt : 5'd0);
    end
  end
  // With forwarding only a load in EX can't supply its result in time
  always_comb begin
    hazard = 1'b0;
    for (int k = 1; k < DEPTH; k++)
      if ((FWD == 0 || (k == 1 && ctrl_q[k][5])) && vld_q[k] && ctrl_q[k][8] && dst_q[k] != 5'd0 &&
          ((use_rs && rs == dst_q[k]) || (use_rt && rt == dst_q[k])))
        hazard = 1'b1;
    hazard = hazard && id_vld_q;
  end
  assign out_stall = hazard && !in_redirect;
  assign out_ready = state_q == RUN && !out_stall;
  assign issue = id_vld_q && !out_stall && !in_redirect && state_q == RUN;
  assign accept = in_valid && out_ready;
  always_comb begin
    any_vld = 1'b0;
    for (int k = 1; k <= DEPTH; k++)
      any_vld = any_vld | vld_q[k];
  end
  always_comb begin
    id_is_d = accept ? in_is : id_is_q;
    id_vld_d = accept || (id_vld_q && !issue && !in_redirect);
    ctrl_d[1] = issue ? dec_ctrl : '0;
    vld_d[1] = issue;
    dst_d[1] = issue ? dec_dst : 5'd0;
    for (int k = 2; k <= DEPTH; k++) begin
      ctrl_d[k] = ctrl_q[k-1];
      vld_d[k] = vld_q[k-1];
      dst_d[k] = dst_q[k-1];
    end
    state_d = (state_q == RUN && issue && dec_ctrl[14]) ? DRAIN :
              (state_q == DRAIN && !any_vld) ? HALT :
              (state_q == HALT && in_resume) ? RUN : state_q;
  end
  always_ff @(posedge in_clk or negedge in_rst_n)
    if (!in_rst_n) begin
      state_q <= RUN;
      id_is_q <= '0;
      id_vld_q <= 1'b0;
      for (int k = 1; k <= DEPTH; k++) begin
        ctrl_q[k] <= '0;
        vld_q[k] <= 1'b0;
        dst_q[k] <= 5'd0;
      end
    end else begin
      state_q <= state_d;
      id_is_q <= id_is_d;
      id_vld_q <= id_vld_d;
      ctrl_q <= ctrl_d;
      vld_q <= vld_d;
      dst_q <= dst_d;
    end
  assign out_ex_ctrl = ctrl_q[1];
  assign out_ex_valid = vld_q[1];
  assign out_mem_ctrl = ctrl_q[2];
  assign out_mem_valid = vld_q[2];
  assign out_wb_ctrl = ctrl_q[DEPTH];
  assign out_wb_valid = vld_q[DEPTH];
  assign out_wb_reg = dst_q[DEPTH];
  assign out_halted = state_q == HALT;
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb_pipe_ctrl_unit: decode table streamed through a scoreboard plus hand-written interlock/flush/halt/reset sequences
module tb_pipe_ctrl_unit;
  localparam int DEPTH = 3;
  logic in_clk = 1'b0, in_rst_n = 1'b0;
  logic [31:0] in_is = '0;
  logic in_valid = 1'b0, in_redirect = 1'b0, in_resume = 1'b0;
  logic out_ready, out_ex_valid, out_mem_valid, out_wb_valid, out_stall, out_halted;
  logic [15:0] out_ex_ctrl, out_mem_ctrl, out_wb_ctrl;
  logic [4:0] out_wb_reg;
  logic r0_ready, r0_ex_valid, r0_mem_valid, r0_wb_valid, r0_stall, r0_halted;
  logic [15:0] r0_ex_ctrl, r0_mem_ctrl, r0_wb_ctrl;
  logic [4:0] r0_wb_reg;

  pipe_ctrl_unit #(.DEPTH(DEPTH), .FWD(1), .CW(16)) u_dut (
    .in_clk(in_clk), .in_rst_n(in_rst_n), .in_is(in_is), .in_valid(in_valid), .out_ready(out_ready),
    .in_redirect(in_redirect), .in_resume(in_resume), .out_ex_ctrl(out_ex_ctrl), .out_ex_valid(out_ex_valid),
    .out_mem_ctrl(out_mem_ctrl), .out_mem_valid(out_mem_valid), .out_wb_ctrl(out_wb_ctrl),
    .out_wb_valid(out_wb_valid), .out_wb_reg(out_wb_reg), .out_stall(out_stall), .out_halted(out_halted));

  pipe_ctrl_unit #(.DEPTH(DEPTH), .FWD(0), .CW(16)) u_dut0 (
    .in_clk(in_clk), .in_rst_n(in_rst_n), .in_is(in_is), .in_valid(in_valid), .out_ready(r0_ready),
    .in_redirect(in_redirect), .in_resume(in_resume), .out_ex_ctrl(r0_ex_ctrl), .out_ex_valid(r0_ex_valid),
    .out_mem_ctrl(r0_mem_ctrl), .out_mem_valid(r0_mem_valid), .out_wb_ctrl(r0_wb_ctrl),
    .out_wb_valid(r0_wb_valid), .out_wb_reg(r0_wb_reg), .out_stall(r0_stall), .out_halted(r0_halted));

  always #5 in_clk = ~in_clk;

  typedef struct {logic [31:0] is; logic [15:0] ctrl; logic [4:0] dst;} vec_t;
  typedef struct {logic [15:0] ctrl; logic [4:0] dst; int edge_n;} sb_t;
  vec_t tbl [22];
  sb_t exq [$];
  sb_t wbq [$];
  int n_chk = 0, n_fail = 0, cnt = 0, s1, s0;
  bit sb_on = 1'b0;
  logic [15:0] exp_ctrl = '0;
  logic [4:0] exp_dst = '0;
  logic pre_ready, pre_stall, pre_stall0, exv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called one time unit after an edge; samples combinational outputs mid-cycle, then advances one edge
  task automatic step();
    sb_t e;
    #3;
    pre_ready = out_ready;
    pre_stall = out_stall;
    pre_stall0 = r0_stall;
    if (sb_on && in_valid && out_ready) exq.push_back('{exp_ctrl, exp_dst, cnt + 1});
    @(posedge in_clk);
    #1;
    cnt++;
    if (sb_on && out_ex_valid) begin
      if (exq.size() == 0) chk("ex_unexpected", 32'd1, 32'd0);
      else begin
        e = exq.pop_front();
        chk("ex_ctrl", {16'd0, out_ex_ctrl}, {16'd0, e.ctrl});
        chk("ex_latency", cnt, e.edge_n + 1);
        wbq.push_back(e);
      end
    end
    if (sb_on && out_wb_valid) begin
      if (wbq.size() == 0) chk("wb_unexpected", 32'd1, 32'd0);
      else begin
        e = wbq.pop_front();
        chk("wb_ctrl", {16'd0, out_wb_ctrl}, {16'd0, e.ctrl});
        chk("wb_reg", {27'd0, out_wb_reg}, {27'd0, e.dst});
        chk("wb_latency", cnt, e.edge_n + DEPTH);
      end
    end
  endtask

  task automatic do_reset();
    in_rst_n = 1'b0;
    in_valid = 1'b0;
    in_redirect = 1'b0;
    in_resume = 1'b0;
    sb_on = 1'b0;
    exq.delete();
    wbq.delete();
    repeat (2) @(posedge in_clk);
    #1;
    in_rst_n = 1'b1;
    cnt = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{32'h00221820, 16'h0100, 5'd3};
    tbl[1]  = '{32'h00224822, 16'h0101, 5'd9};
    tbl[2]  = '{32'h00225024, 16'h0102, 5'd10};
    tbl[3]  = '{32'h00225825, 16'h0103, 5'd11};
    tbl[4]  = '{32'h0022602A, 16'h0104, 5'd12};
    tbl[5]  = '{32'h00026900, 16'h0105, 5'd13};
    tbl[6]  = '{32'h00027042, 16'h0106, 5'd14};
    tbl[7]  = '{32'h20280005, 16'h0110, 5'd8};
    tbl[8]  = '{32'h302900FF, 16'h0112, 5'd9};
    tbl[9]  = '{32'h342A0001, 16'h0113, 5'd10};
    tbl[10] = '{32'h282B0003, 16'h0114, 5'd11};
    tbl[11] = '{32'h8C2F0000, 16'h0130, 5'd15};
    tbl[12] = '{32'hAC220004, 16'h0050, 5'd0};
    tbl[13] = '{32'hA4220006, 16'h00D0, 5'd0};
    tbl[14] = '{32'h10220008, 16'h0801, 5'd0};
    tbl[15] = '{32'h14220008, 16'h1001, 5'd0};
    tbl[16] = '{32'h08000100, 16'h0200, 5'd0};
    tbl[17] = '{32'h0C000100, 16'h2300, 5'd31};
    tbl[18] = '{32'h00200008, 16'h0400, 5'd0};
    tbl[19] = '{32'h42000018, 16'h8000, 5'd0};
    tbl[20] = '{32'hFC000000, 16'h0000, 5'd0};
    tbl[21] = '{32'h0000003F, 16'h0000, 5'd0};

    do_reset();
    chk("reset_flags", {27'd0, out_ex_valid, out_mem_valid, out_wb_valid, out_stall, out_halted}, 32'd0);
    chk("reset_ctrl", {out_ex_ctrl, out_mem_ctrl}, 32'd0);
    chk("reset_wb", {11'd0, out_wb_ctrl, out_wb_reg}, 32'd0);
    chk("reset_ready", {31'd0, out_ready}, 32'd1);

    // Gap-free stream of every decodable form, checked at EX and WB with exact latency
    sb_on = 1'b1;
    for (int i = 0; i < 22; i++) begin
      in_valid = 1'b1;
      in_is = tbl[i].is;
      exp_ctrl = tbl[i].ctrl;
      exp_dst = tbl[i].dst;
      step();
      chk("stream_ready", {31'd0, pre_ready}, 32'd1);
    end
    in_valid = 1'b0;
    repeat (DEPTH + 2) step();
    chk("sb_drained", exq.size() + wbq.size(), 32'd0);
    sb_on = 1'b0;

    // Load-use: FWD=1 stalls once, FWD=0 stalls until the load leaves stage DEPTH-1
    do_reset();
    in_valid = 1'b1;
    in_is = 32'h8CA40000;
    step();
    in_is = 32'h00843020;
    step();
    in_valid = 1'b0;
    s1 = 0;
    s0 = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      s1 += int'(pre_stall);
      s0 += int'(pre_stall0);
      if (i == 0) chk("lu_bubble", {15'd0, out_ex_valid, out_ex_ctrl}, 32'd0);
      if (i == 1) chk("lu_issue", {15'd0, out_ex_valid, out_ex_ctrl}, {15'd0, 1'b1, 16'h0100});
    end
    chk("lu_stall_fwd1", s1, 32'd1);
    chk("lu_stall_fwd0", s0, 32'd2);

    // Taken branch in EX flushes ori in ID; target accepted in the same cycle
    do_reset();
    in_valid = 1'b1;
    in_is = 32'h10220008;
    step();
    in_is = 32'h342A0001;
    step();
    in_redirect = 1'b1;
    in_is = 32'h00221820;
    step();
    chk("redir_ready", {31'd0, pre_ready}, 32'd1);
    chk("redir_bubble", {15'd0, out_ex_valid, out_ex_ctrl}, 32'd0);
    chk("redir_mem_beq", {15'd0, out_mem_valid, out_mem_ctrl}, {15'd0, 1'b1, 16'h0801});
    in_redirect = 1'b0;
    in_valid = 1'b0;
    step();
    chk("redir_target", {15'd0, out_ex_valid, out_ex_ctrl}, {15'd0, 1'b1, 16'h0100});

    // Redirect coincident with load-use: no stall, dependent instruction dropped
    do_reset();
    in_valid = 1'b1;
    in_is = 32'h8CA40000;
    step();
    in_is = 32'h00843020;
    step();
    in_valid = 1'b0;
    in_redirect = 1'b1;
    step();
    chk("rlu_no_stall", {30'd0, pre_stall, pre_stall0}, 32'd0);
    chk("rlu_ready", {31'd0, pre_ready}, 32'd1);
    in_redirect = 1'b0;
    exv = out_ex_valid;
    repeat (4) begin
      step();
      exv = exv | out_ex_valid;
    end
    chk("rlu_dropped", {31'd0, exv}, 32'd0);

    // Syscall drains, halts, ignores early resume, then resumes
    do_reset();
    in_valid = 1'b1;
    in_is = 32'h0000000C;
    step();
    in_is = 32'h00221820;
    step();
    chk("sys_next_accepted", {31'd0, pre_ready}, 32'd1);
    in_resume = 1'b1;
    step();
    in_resume = 1'b0;
    chk("drain_ready0", {31'd0, pre_ready}, 32'd0);
    step();
    chk("drain_ready1", {31'd0, pre_ready}, 32'd0);
    chk("sys_retire", {15'd0, out_wb_valid, out_wb_ctrl}, {15'd0, 1'b1, 16'h4000});
    step();
    chk("wb_empty_not_halted", {30'd0, out_wb_valid, out_halted}, 32'd0);
    step();
    chk("halted", {31'd0, out_halted}, 32'd1);
    repeat (3) begin
      step();
      chk("halt_hold", {30'd0, pre_ready, out_halted}, 32'd1);
    end
    in_resume = 1'b1;
    step();
    in_resume = 1'b0;
    chk("resume_cycle_ready", {31'd0, pre_ready}, 32'd0);
    chk("resumed", {31'd0, out_halted}, 32'd0);
    in_is = 32'h00225825;
    step();
    chk("resume_ready", {31'd0, pre_ready}, 32'd1);
    chk("resume_issue", {15'd0, out_ex_valid, out_ex_ctrl}, {15'd0, 1'b1, 16'h0100});
    in_valid = 1'b0;
    step();
    chk("resume_next", {15'd0, out_ex_valid, out_ex_ctrl}, {15'd0, 1'b1, 16'h0103});

    // Asynchronous reset mid-stream
    do_reset();
    in_valid = 1'b1;
    in_is = 32'h00221820;
    repeat (4) step();
    #2;
    in_rst_n = 1'b0;
    #1;
    chk("async_rst_valids", {29'd0, out_ex_valid, out_mem_valid, out_wb_valid}, 32'd0);
    chk("async_rst_ctrl", {out_ex_ctrl, out_wb_ctrl}, 32'd0);
    @(posedge in_clk);
    #1;
    in_rst_n = 1'b1;
    in_valid = 1'b0;
    step();
    chk("async_rst_no_retire", {30'd0, out_ex_valid, out_wb_valid}, 32'd0);

    // Asynchronous reset while halted
    do_reset();
    in_valid = 1'b1;
    in_is = 32'h0000000C;
    step();
    in_valid = 1'b0;
    repeat (6) step();
    chk("halt_before_rst", {31'd0, out_halted}, 32'd1);
    #2;
    in_rst_n = 1'b0;
    #1;
    chk("async_rst_halted", {31'd0, out_halted}, 32'd0);
    @(posedge in_clk);
    #1;
    in_rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
